// File: rtl/branch_resolve_unit.sv
// Purpose: carries gshare prediction metadata through IF/ID and ID/EX and resolves it at EX.
// Latency: EX outputs are combinational from ID/EX state (0 cycles); counters update at the edge.
// Backpressure: stall holds IF/ID and bubbles ID/EX; flush kills both stages and wins over stall.
module branch_resolve_unit #(
   parameter int PHT_IDX_W = 5,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 if_valid,
   input  logic [31:0]          if_pc,
   input  logic [31:0]          if_pred_next_pc,
   input  logic [PHT_IDX_W-1:0] if_pht_index,
   input  logic                 ex_is_branch,
   input  logic                 ex_is_jal,
   input  logic                 ex_is_jalr,
   input  logic                 ex_branch_cond,
   input  logic [31:0]          ex_target,
   output logic                 is_branch,
   output logic                 is_jal,
   output logic                 is_jalr,
   output logic                 actual_taken,
   output logic [31:0]          actual_branch_target,
   output logic                 prediction_correct,
   output logic [PHT_IDX_W-1:0] pht_update_index,
   output logic [31:0]          ID_EX_pc,
   output logic                 flush,
   output logic [31:0]          redirect_pc,
   output logic [CNT_W-1:0]     branch_count,
   output logic [CNT_W-1:0]     mispredict_count
);

   logic                 if_id_vld_q, if_id_vld_d;
   logic [31:0]          if_id_pc_q, if_id_pc_d;
   logic [31:0]          if_id_pred_q, if_id_pred_d;
   logic [PHT_IDX_W-1:0] if_id_idx_q, if_id_idx_d;
   logic                 id_ex_vld_q, id_ex_vld_d;
   logic [31:0]          id_ex_pc_q, id_ex_pc_d;
   logic [31:0]          id_ex_pred_q, id_ex_pred_d;
   logic [PHT_IDX_W-1:0] id_ex_idx_q, id_ex_idx_d;
   logic [CNT_W-1:0]     branch_count_q, branch_count_d;
   logic [CNT_W-1:0]     mispredict_count_q, mispredict_count_d;

   logic        taken_raw;
   logic        any_ctrl;
   logic [31:0] actual_next;

   // EX resolution: compare predicted next pc with the resolved one; all outputs gated by valid
   always_comb begin
      any_ctrl             = ex_is_branch | ex_is_jal | ex_is_jalr;
      // several ex_is_* at once is illegal; any jal/jalr bit makes it resolve taken
      taken_raw            = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_branch_cond);
      actual_next          = taken_raw ? ex_target : id_ex_pc_q + 32'd4;
      prediction_correct   = !id_ex_vld_q || (id_ex_pred_q == actual_next);
      flush                = id_ex_vld_q & !prediction_correct;
      redirect_pc          = id_ex_vld_q ? actual_next : 32'd0;
      is_branch            = id_ex_vld_q & ex_is_branch;
      is_jal               = id_ex_vld_q & ex_is_jal;
      is_jalr              = id_ex_vld_q & ex_is_jalr;
      actual_taken         = id_ex_vld_q & taken_raw;
      actual_branch_target = id_ex_vld_q ? ex_target : 32'd0;
      pht_update_index     = id_ex_vld_q ? id_ex_idx_q : '0;
      ID_EX_pc             = id_ex_pc_q;
      branch_count         = branch_count_q;
      mispredict_count     = mispredict_count_q;
   end

   // Stage advance: flush beats stall beats normal shift; bubbles carry an all-zero payload
   always_comb begin
      if_id_vld_d  = if_id_vld_q;
      if_id_pc_d   = if_id_pc_q;
      if_id_pred_d = if_id_pred_q;
      if_id_idx_d  = if_id_idx_q;
      id_ex_vld_d  = 1'b0;
      id_ex_pc_d   = 32'd0;
      id_ex_pred_d = 32'd0;
      id_ex_idx_d  = '0;
      if (flush) begin
         if_id_vld_d = 1'b0;
      end else if (!stall) begin
         if_id_vld_d  = if_valid;
         if_id_pc_d   = if_pc;
         if_id_pred_d = if_pred_next_pc;
         if_id_idx_d  = if_pht_index;
         id_ex_vld_d  = if_id_vld_q;
         id_ex_pc_d   = if_id_pc_q;
         id_ex_pred_d = if_id_pred_q;
         id_ex_idx_d  = if_id_idx_q;
      end
   end

   // Statistics: count each resolved control instruction and each misprediction, wrapping
   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (id_ex_vld_q && any_ctrl) begin
         branch_count_d = branch_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush) begin
         mispredict_count_d = mispredict_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // State registers with synchronous active-low reset that drops all in-flight metadata
   always_ff @(posedge clk) begin
      if (!reset) begin
         if_id_vld_q        <= 1'b0;
         if_id_pc_q         <= 32'd0;
         if_id_pred_q       <= 32'd0;
         if_id_idx_q        <= '0;
         id_ex_vld_q        <= 1'b0;
         id_ex_pc_q         <= 32'd0;
         id_ex_pred_q       <= 32'd0;
         id_ex_idx_q        <= '0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         if_id_vld_q        <= if_id_vld_d;
         if_id_pc_q         <= if_id_pc_d;
         if_id_pred_q       <= if_id_pred_d;
         if_id_idx_q        <= if_id_idx_d;
         id_ex_vld_q        <= id_ex_vld_d;
         id_ex_pc_q         <= id_ex_pc_d;
         id_ex_pred_q       <= id_ex_pred_d;
         id_ex_idx_q        <= id_ex_idx_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: stage-level model checked every cycle plus literal expectations.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Runs a fixed directed sequence, then prints one summary line.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        reset, stall, if_valid;
   logic [31:0] if_pc, if_pred_next_pc;
   logic [4:0]  if_pht_index;
   logic        ex_is_branch, ex_is_jal, ex_is_jalr, ex_branch_cond;
   logic [31:0] ex_target;
   logic        is_branch, is_jal, is_jalr, actual_taken, prediction_correct, flush;
   logic [31:0] actual_branch_target, ID_EX_pc, redirect_pc, branch_count, mispredict_count;
   logic [4:0]  pht_update_index;

   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.PHT_IDX_W(5), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .stall(stall), .if_valid(if_valid), .if_pc(if_pc),
      .if_pred_next_pc(if_pred_next_pc), .if_pht_index(if_pht_index),
      .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
      .ex_branch_cond(ex_branch_cond), .ex_target(ex_target),
      .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .actual_taken(actual_taken),
      .actual_branch_target(actual_branch_target), .prediction_correct(prediction_correct),
      .pht_update_index(pht_update_index), .ID_EX_pc(ID_EX_pc), .flush(flush),
      .redirect_pc(redirect_pc), .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        vld;
      logic [31:0] pc;
      logic [31:0] pred;
      logic [4:0]  idx;
   } ent_t;

   ent_t        m_ifid, m_idex;
   logic [31:0] m_bc, m_mc;
   logic        e_any, e_taken, e_ok, e_flush;
   logic [31:0] e_next;

   always_comb begin
      e_any   = ex_is_branch | ex_is_jal | ex_is_jalr;
      e_taken = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_branch_cond);
      e_next  = e_taken ? ex_target : m_idex.pc + 32'd4;
      e_ok    = !m_idex.vld || (m_idex.pred == e_next);
      e_flush = !e_ok;
   end

   always @(posedge clk) begin
      if (!reset) begin
         m_ifid <= '0;
         m_idex <= '0;
         m_bc   <= 32'd0;
         m_mc   <= 32'd0;
      end else begin
         if (m_idex.vld && e_any) m_bc <= m_bc + 32'd1;
         if (e_flush) m_mc <= m_mc + 32'd1;
         if (e_flush) begin
            m_ifid.vld <= 1'b0;
            m_idex.vld <= 1'b0;
         end else if (stall) begin
            m_idex.vld <= 1'b0;
         end else begin
            m_idex <= m_ifid;
            m_ifid <= '{vld: if_valid, pc: if_pc, pred: if_pred_next_pc, idx: if_pht_index};
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_is_branch", 32'(is_branch), 32'(m_idex.vld & ex_is_branch));
         chk("m_is_jal", 32'(is_jal), 32'(m_idex.vld & ex_is_jal));
         chk("m_is_jalr", 32'(is_jalr), 32'(m_idex.vld & ex_is_jalr));
         chk("m_actual_taken", 32'(actual_taken), 32'(m_idex.vld & e_taken));
         chk("m_target", actual_branch_target, m_idex.vld ? ex_target : 32'd0);
         chk("m_pht_idx", 32'(pht_update_index), m_idex.vld ? 32'(m_idex.idx) : 32'd0);
         chk("m_pred_ok", 32'(prediction_correct), 32'(e_ok));
         chk("m_flush", 32'(flush), 32'(e_flush));
         if (m_idex.vld) chk("m_id_ex_pc", ID_EX_pc, m_idex.pc);
         if (e_flush) chk("m_redirect", redirect_pc, e_next);
         chk("m_branch_count", branch_count, m_bc);
         chk("m_mispredict_count", mispredict_count, m_mc);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 1'b0; if_valid = 1'b0; if_pc = 32'd0; if_pred_next_pc = 32'd0; if_pht_index = 5'd0;
      ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0; ex_branch_cond = 1'b0;
      ex_target = 32'd0;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic [31:0] pred, input logic [4:0] idx);
      if_valid = 1'b1; if_pc = pc; if_pred_next_pc = pred; if_pht_index = idx;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      idle();
      reset = 1'b0;

      // 1: reset state
      do_reset();
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_pred_ok", 32'(prediction_correct), 32'd1);
      chk("rst_taken", 32'(actual_taken), 32'd0);
      chk("rst_id_ex_pc", ID_EX_pc, 32'd0);
      chk("rst_counts", branch_count | mispredict_count, 32'd0);

      // 2: taken branch predicted not-taken
      fetch(32'h40, 32'h44, 5'd5); tick();
      idle(); tick();
      ex_is_branch = 1'b1; ex_branch_cond = 1'b1; ex_target = 32'h80; #1;
      chk("t2_flush", 32'(flush), 32'd1);
      chk("t2_redirect", redirect_pc, 32'h80);
      chk("t2_is_branch", 32'(is_branch), 32'd1);
      chk("t2_taken", 32'(actual_taken), 32'd1);
      chk("t2_pht_idx", 32'(pht_update_index), 32'd5);
      tick(); idle(); #1;
      chk("t2_mispredict_count", mispredict_count, 32'd1);
      chk("t2_branch_count", branch_count, 32'd1);

      // 3: taken branch predicted correctly
      do_reset();
      fetch(32'h40, 32'h80, 5'd7); tick();
      idle(); tick();
      ex_is_branch = 1'b1; ex_branch_cond = 1'b1; ex_target = 32'h80; #1;
      chk("t3_pred_ok", 32'(prediction_correct), 32'd1);
      chk("t3_flush", 32'(flush), 32'd0);
      tick(); idle(); #1;
      chk("t3_branch_count", branch_count, 32'd1);
      chk("t3_mispredict_count", mispredict_count, 32'd0);

      // 4: non-control instruction with a stale prediction
      do_reset();
      fetch(32'h10, 32'h200, 5'd3); tick();
      idle(); tick(); #1;
      chk("t4_flush", 32'(flush), 32'd1);
      chk("t4_redirect", redirect_pc, 32'h14);
      tick(); #1;
      chk("t4_branch_count", branch_count, 32'd0);
      chk("t4_mispredict_count", mispredict_count, 32'd1);

      // 5: stall with jal held in IF/ID
      do_reset();
      fetch(32'h20, 32'h100, 5'd9); tick();
      idle(); stall = 1'b1; tick();
      stall = 1'b0; #1;
      chk("t5_bubble_jal", 32'(is_jal), 32'd0);
      chk("t5_bubble_flush", 32'(flush), 32'd0);
      chk("t5_bubble_pht", 32'(pht_update_index), 32'd0);
      tick();
      ex_is_jal = 1'b1; ex_target = 32'h100; #1;
      chk("t5_id_ex_pc", ID_EX_pc, 32'h20);
      chk("t5_is_jal", 32'(is_jal), 32'd1);
      chk("t5_flush", 32'(flush), 32'd0);
      tick(); idle(); #1;
      chk("t5_branch_count", branch_count, 32'd1);

      // 6: flush and stall together discard the stalled IF/ID entry
      do_reset();
      fetch(32'h10, 32'h200, 5'd1); tick();
      fetch(32'h14, 32'h18, 5'd2); tick();
      idle(); stall = 1'b1; #1;
      chk("t6_flush", 32'(flush), 32'd1);
      tick();
      stall = 1'b0; ex_is_branch = 1'b1; ex_branch_cond = 1'b1; ex_target = 32'h300; #1;
      chk("t6_no_update_a", 32'(is_branch), 32'd0);
      chk("t6_no_flush_a", 32'(flush), 32'd0);
      tick(); #1;
      chk("t6_no_update_b", 32'(is_branch), 32'd0);
      chk("t6_mispredict_count", mispredict_count, 32'd1);
      idle();

      // 7: illegal jal+branch with cond=0 resolves taken; jalr mispredict
      do_reset();
      fetch(32'h60, 32'h64, 5'd4); tick();
      fetch(32'h70, 32'h74, 5'd6); tick();
      if_valid = 1'b0;
      ex_is_jal = 1'b1; ex_is_branch = 1'b1; ex_branch_cond = 1'b0; ex_target = 32'h90; #1;
      chk("t7_taken", 32'(actual_taken), 32'd1);
      chk("t7_redirect", redirect_pc, 32'h90);
      tick(); idle(); tick();
      fetch(32'hFFFF_FFFC, 32'h0, 5'd31); tick();
      idle(); tick();
      ex_is_jalr = 1'b1; ex_target = 32'h500; #1;
      chk("t7_jalr_redirect", redirect_pc, 32'h500);
      tick(); idle();
      // wrap of pc+4: non-control at 0xFFFFFFFC predicted 0x0 is correct
      fetch(32'hFFFF_FFFC, 32'h0, 5'd0); tick();
      idle(); tick(); #1;
      chk("t7_wrap_pred_ok", 32'(prediction_correct), 32'd1);

      // mid-flight reset leaves no pending update
      fetch(32'h80, 32'h1234, 5'd8); tick();
      idle(); reset = 1'b0; tick(); tick();
      reset = 1'b1; #1;
      chk("rst_mid_flush", 32'(flush), 32'd0);
      tick(); #1;
      chk("rst_mid_counts", branch_count | mispredict_count, 32'd0);
      tick();

      @(negedge clk);
      chk_en = 1'b0;
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
